// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, branch redirects and data-memory waits,
// with a sticky memory-timeout flag and saturating stall/flush performance counters.
module hazard_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             DmemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LU    = 2'd1,
        MWAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               load_use, mem_busy, redirect;

    assign load_use = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_busy = MemReqM && !DmemReadyM;

    // Next state and same-cycle stall/flush controls, priority MemBusy > PCSrcE > LoadUse.
    always_comb begin
        state_d  = RUN;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushW   = 1'b0;
        redirect = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_busy) begin
            // StallE also parks any pending redirect until memory releases.
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            StallM  = 1'b1;
            FlushW  = 1'b1;
            state_d = MWAIT;
        end else if (PCSrcE) begin
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            redirect = 1'b1;
        end else if (load_use && (state_q != LU)) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            FlushE  = 1'b1;
            state_d = LU;
        end
    end

    // Consecutive memory-busy cycle count and sticky timeout.
    always_comb begin
        wait_inc  = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
        wait_d    = mem_busy ? wait_inc : '0;
        timeout_d = timeout_q || (mem_busy && (wait_inc == WAIT_W'(TIMEOUT_CYCLES)));
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a vector table plus hand-written multi-cycle sequences.
module tb_hazard_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] rs1, rs2, rd;
    logic       mr, pc, mq, rdy;

    logic        sf_a, sd_a, se_a, sm_a, fd_a, fe_a, fw_a, to_a;
    logic [15:0] sc_a, fc_a;
    logic        sf_b, sd_b, se_b, sm_b, fd_b, fe_b, fw_b, to_b;
    logic [1:0]  sc_b, fc_b;

    hazard_controller #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Rs1D(rs1), .Rs2D(rs2), .RdE(rd),
        .MemReadE(mr), .PCSrcE(pc), .MemReqM(mq), .DmemReadyM(rdy),
        .StallF(sf_a), .StallD(sd_a), .StallE(se_a), .StallM(sm_a),
        .FlushD(fd_a), .FlushE(fe_a), .FlushW(fw_a),
        .MemTimeout(to_a), .StallCount(sc_a), .FlushCount(fc_a)
    );

    // Default timeout, 2-bit counters to expose saturation.
    hazard_controller #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .Rs1D(rs1), .Rs2D(rs2), .RdE(rd),
        .MemReadE(mr), .PCSrcE(pc), .MemReqM(mq), .DmemReadyM(rdy),
        .StallF(sf_b), .StallD(sd_b), .StallE(se_b), .StallM(sm_b),
        .FlushD(fd_b), .FlushE(fe_b), .FlushW(fw_b),
        .MemTimeout(to_b), .StallCount(sc_b), .FlushCount(fc_b)
    );

    wire [3:0] stall_a = {sf_a, sd_a, se_a, sm_a};
    wire [2:0] flush_a = {fd_a, fe_a, fw_a};

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       mr, pc, mq, rdy;
        logic [3:0] stall;  // {F,D,E,M}
        logic [2:0] flush;  // {D,E,W}
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [4:0] a, b, d, input logic m, p, q, r,
                                input logic [3:0] st, input logic [2:0] fl);
        vec_t v;
        v.rs1 = a; v.rs2 = b; v.rd = d;
        v.mr = m; v.pc = p; v.mq = q; v.rdy = r;
        v.stall = st; v.flush = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a, b, d, input logic m, p, q, r);
        rs1 = a; rs2 = b; rd = d; mr = m; pc = p; mq = q; rdy = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        //            rs1    rs2    rd    mr pc mq rdy  stall    flush
        vecs[0]  = mk(5'd0,  5'd0,  5'd0, 0, 0, 0, 0, 4'b0000, 3'b000); // idle
        vecs[1]  = mk(5'd5,  5'd0,  5'd5, 1, 0, 0, 0, 4'b1100, 3'b010); // load-use on rs1
        vecs[2]  = mk(5'd5,  5'd0,  5'd5, 1, 0, 0, 0, 4'b0000, 3'b000); // LU lasts one cycle
        vecs[3]  = mk(5'd3,  5'd7,  5'd7, 1, 0, 0, 0, 4'b1100, 3'b010); // load-use on rs2
        vecs[4]  = mk(5'd3,  5'd7,  5'd7, 1, 1, 0, 0, 4'b0000, 3'b110); // redirect in LU
        vecs[5]  = mk(5'd0,  5'd0,  5'd0, 1, 0, 0, 0, 4'b0000, 3'b000); // rd=x0 never hazards
        vecs[6]  = mk(5'd5,  5'd0,  5'd5, 0, 0, 0, 0, 4'b0000, 3'b000); // not a load
        vecs[7]  = mk(5'd9,  5'd0,  5'd9, 1, 1, 0, 0, 4'b0000, 3'b110); // redirect beats load-use
        vecs[8]  = mk(5'd9,  5'd0,  5'd9, 1, 1, 1, 0, 4'b1111, 3'b001); // mem busy beats all
        vecs[9]  = mk(5'd9,  5'd0,  5'd9, 1, 0, 1, 1, 4'b1100, 3'b010); // release, load-use
        vecs[10] = mk(5'd0,  5'd0,  5'd0, 0, 0, 0, 0, 4'b0000, 3'b000);
        vecs[11] = mk(5'd0,  5'd0,  5'd0, 0, 0, 1, 0, 4'b1111, 3'b001); // single busy cycle
        vecs[12] = mk(5'd0,  5'd0,  5'd0, 0, 0, 0, 0, 4'b0000, 3'b000);
        vecs[13] = mk(5'd0,  5'd0,  5'd0, 0, 0, 1, 1, 4'b0000, 3'b000); // ready same cycle

        // Outputs while reset is held, then reset values.
        reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_stall", 32'(stall_a), 32'h0);
        chk("reset_flush", 32'(flush_a), 32'h7);
        cyc();
        chk("reset_counts", {sc_a, fc_a}, 32'h0);
        chk("reset_timeout", 32'(to_a), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].pc,
                  vecs[i].mq, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall_a), 32'(vecs[i].stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush_a), 32'(vecs[i].flush));
            cyc();
        end
        chk("table_stallcount", 32'(sc_a), 32'd5);
        chk("table_flushcount", 32'(fc_a), 32'd2);
        chk("table_stallcount_sat", 32'(sc_b), 32'd3);
        chk("table_flushcount_sat", 32'(fc_b), 32'd2);
        chk("table_timeout", 32'(to_a), 32'd0);

        // Redirect held across three busy cycles, applied on release.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("mwait%0d_stall", i), 32'(stall_a), 32'hF);
            chk($sformatf("mwait%0d_flush", i), 32'(flush_a), 32'h1);
            cyc();
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("release_stall", 32'(stall_a), 32'h0);
        chk("release_flush", 32'(flush_a), 32'h6);
        cyc();
        chk("mwait_stallcount", 32'(sc_a), 32'd3);
        chk("mwait_flushcount", 32'(fc_a), 32'd1);

        // Timeout after the fourth consecutive busy cycle, sticky after release.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            chk($sformatf("busy%0d_stall", i), 32'(stall_a), 32'hF);
            cyc();
            chk($sformatf("busy%0d_timeout", i), 32'(to_a), (i >= 3) ? 32'd1 : 32'd0);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("after_busy_stall", 32'(stall_a), 32'h0);
        cyc();
        chk("timeout_sticky", 32'(to_a), 32'd1);
        chk("timeout_default_param", 32'(to_b), 32'd0);
        chk("busy_stallcount", 32'(sc_a), 32'd6);

        // Reset in the middle of a memory wait.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        chk("rst_mwait_stall", 32'(stall_a), 32'h0);
        chk("rst_mwait_flush", 32'(flush_a), 32'h7);
        cyc();
        chk("rst_mwait_counts", {sc_a, fc_a}, 32'h0);
        chk("rst_mwait_timeout", 32'(to_a), 32'd0);
        #1;
        chk("rst_held_flush", 32'(flush_a), 32'h7);

        // Reset in the middle of a load-use bubble.
        reset = 1'b0;
        drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_pre_stall", 32'(stall_a), 32'hC);
        cyc();
        reset = 1'b1;
        #1;
        chk("rst_lu_flush", 32'(flush_a), 32'h7);
        cyc();
        reset = 1'b0;
        #1;
        chk("post_rst_lu_stall", 32'(stall_a), 32'hC);
        chk("post_rst_lu_flush", 32'(flush_a), 32'h2);
        cyc();
        chk("post_rst_stallcount", 32'(sc_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
